// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer and its condition evaluator:
// op codes, flag/status bit positions, condition codes and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADD1 = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_ADD3 = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_SLL  = 3'b110;
    localparam logic [2:0] OP_MOV  = 3'b111;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_V = 1;
    localparam int F_C = 0;

    localparam int STAT_HI = 15;
    localparam int STAT_LO = 12;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_CS = 3'b101;
    localparam logic [2:0] COND_VS = 3'b110;
    localparam logic [2:0] COND_NV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sequencer_cond_eval.sv
// Branch condition evaluation from a committed {Z,N,V,C} flag vector.
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond_sel,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_sel)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = flags[F_Z];
            COND_NE: cond_true = !flags[F_Z];
            COND_LT: cond_true = flags[F_N] ^ flags[F_V];
            COND_GE: cond_true = !(flags[F_N] ^ flags[F_V]);
            COND_CS: cond_true = flags[F_C];
            COND_VS: cond_true = flags[F_V];
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Initiator side of the 16-bit ALU: issues one op at a time, waits the
// settle time, returns the result and commits architectural flags.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MUL_WAIT = 2,
    parameter int DST_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [DST_W-1:0] cmd_dst,
    input  logic             cmd_setflags,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [15:0]      alu_status,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [WIDTH-1:0] wb_data,
    output logic [DST_W-1:0] wb_dst,
    output logic [3:0]       flags,
    input  logic [2:0]       cond_sel,
    output logic             cond_true,
    output logic             busy
);

    state_t     state;
    logic [2:0] cnt;
    logic       setflags;
    logic [3:0] pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            setflags  <= 1'b0;
            pending   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            alu_data1 <= '0;
            alu_data2 <= '0;
            alu_ctrl  <= '0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_dst    <= '0;
            flags     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        alu_data1 <= cmd_a;
                        alu_data2 <= cmd_b;
                        alu_ctrl  <= cmd_op;
                        wb_dst    <= cmd_dst;
                        setflags  <= cmd_setflags;
                        cnt       <= (cmd_op == OP_MUL) ? 3'(MUL_WAIT) : 3'd0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        // Z/N come from the result itself; only V/C trust the ALU.
                        wb_data      <= alu_result;
                        pending[F_Z] <= (alu_result == '0);
                        pending[F_N] <= alu_result[WIDTH-1];
                        pending[F_V] <= alu_status[STAT_LO+1];
                        pending[F_C] <= alu_status[STAT_LO];
                        wb_valid     <= 1'b1;
                        state        <= WB;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        if (setflags) flags <= pending;
                        wb_valid  <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    alu_cond_eval u_cond (
        .flags    (flags),
        .cond_sel (cond_sel),
        .cond_true(cond_true)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU in the loop.
module tb_alu_sequencer;

    localparam int WIDTH = 16;
    localparam int DST_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [DST_W-1:0] cmd_dst;
    logic             cmd_setflags;
    logic [WIDTH-1:0] alu_data1;
    logic [WIDTH-1:0] alu_data2;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic [15:0]      alu_status;
    logic             wb_valid;
    logic             wb_ready;
    logic [WIDTH-1:0] wb_data;
    logic [DST_W-1:0] wb_dst;
    logic [3:0]       flags;
    logic [2:0]       cond_sel;
    logic             cond_true;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [DST_W-1:0] dst;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(WIDTH), .MUL_WAIT(2), .DST_W(DST_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_dst     (cmd_dst),
        .cmd_setflags(cmd_setflags),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_status  (alu_status),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_dst      (wb_dst),
        .flags       (flags),
        .cond_sel    (cond_sel),
        .cond_true   (cond_true),
        .busy        (busy)
    );

    // Behavioural ALU; status Z/N bits are deliberately inverted so the
    // sequencer must derive them from the result.
    always_comb begin
        logic [WIDTH:0] ext;
        logic           v;
        ext = '0;
        v   = 1'b0;
        case (alu_ctrl)
            3'b000: begin
                ext = {1'b0, alu_data1} + {1'b0, alu_data2};
                v = (alu_data1[15] == alu_data2[15]) && (ext[15] != alu_data1[15]);
            end
            3'b001: ext = {1'b0, alu_data1} + {1'b0, alu_data2} + 17'd1;
            3'b010: begin
                ext = {1'b0, alu_data1} - {1'b0, alu_data2};
                v = (alu_data1[15] != alu_data2[15]) && (ext[15] != alu_data1[15]);
            end
            3'b011: ext = {1'b0, alu_data1} + {1'b0, alu_data2} + 17'd3;
            3'b100: ext = {1'b0, alu_data1 * alu_data2};
            3'b101: ext = {1'b0, alu_data1 & alu_data2};
            3'b110: ext = {1'b0, alu_data1 << alu_data2[3:0]};
            default: ext = {1'b0, alu_data2};
        endcase
        alu_result = ext[15:0];
        alu_status = {~(ext[15:0] == 16'h0), ~ext[15], v, ext[16], 12'h0};
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got data 0x%0h expected none", wb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_data", 32'(wb_data), 32'(e.data));
                check("wb_dst", 32'(wb_dst), 32'(e.dst));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return one cycle after the accept edge (T+1).
    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] dst,
                         input logic sf, input bit expect_wb,
                         input logic [15:0] exp_data);
        int n;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_dst = dst;
        cmd_setflags = sf; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 0, 1);
        if (expect_wb) sb.push_back('{data: exp_data, dst: dst});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_wb();
        int n;
        n = 0;
        while (!wb_valid && n < 20) begin
            tick();
            n++;
        end
        if (!wb_valid) check("wb_timeout", 0, 1);
    endtask

    task automatic handshake();
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    logic [7:0] cond_exp;
    bit         saw_wb;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_dst = '0; cmd_setflags = 1'b0; wb_ready = 1'b0; cond_sel = 3'b000;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_alu_ops", {alu_data1, alu_data2}, 0);

        // add with signed overflow
        issue(3'b000, 16'h7FFF, 16'h0001, 3'd1, 1'b1, 1'b1, 16'h8000);
        check("add_t1_valid", 32'(wb_valid), 0);
        check("add_t1_busy", 32'(busy), 1);
        tick();
        check("add_t2_valid", 32'(wb_valid), 1);
        check("add_wb_old_flags", 32'(flags), 0);
        handshake();
        check("add_flags", 32'(flags), 32'h6);
        cond_sel = 3'b011;
        #1 check("add_cond_lt", 32'(cond_true), 0);

        // multiply: two extra settle cycles
        issue(3'b100, 16'h0003, 16'hFFFE, 3'd2, 1'b0, 1'b1, 16'hFFFA);
        for (int i = 1; i <= 3; i++) begin
            check("mul_wait_valid", 32'(wb_valid), 0);
            check("mul_wait_ready", 32'(cmd_ready), 0);
            tick();
        end
        check("mul_t4_valid", 32'(wb_valid), 1);
        check("mul_t4_ready", 32'(cmd_ready), 0);
        handshake();

        // subtract to zero without committing flags
        issue(3'b010, 16'h0005, 16'h0005, 3'd3, 1'b0, 1'b1, 16'h0000);
        wait_wb();
        check("sub_busy_wb", 32'(busy), 1);
        handshake();
        check("sub_busy_after", 32'(busy), 0);
        check("sub_flags_kept", 32'(flags), 32'h6);

        // backpressure on pass-through, with an ignored second command
        issue(3'b111, 16'h0BAD, 16'h1234, 3'd5, 1'b0, 1'b1, 16'h1234);
        wait_wb();
        cmd_op = 3'b101; cmd_a = 16'hFFFF; cmd_b = 16'h00FF;
        cmd_dst = 3'd6; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_data", 32'(wb_data), 32'h1234);
            check("bp_dst", 32'(wb_dst), 5);
            check("bp_ready", 32'(cmd_ready), 0);
            tick();
        end
        check("bp_ctrl_held", {alu_ctrl, alu_data2}, {3'b111, 16'h1234});
        cmd_valid = 1'b0;
        handshake();
        tick();
        check("bp_idle", 32'(cmd_ready), 1);

        // reset during multiply EXEC
        issue(3'b100, 16'h0002, 16'h0002, 3'd4, 1'b1, 1'b0, 16'h0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", 32'(wb_valid), 0);
        check("rst_mid_flags", 32'(flags), 0);
        check("rst_mid_ready", 32'(cmd_ready), 1);
        check("rst_mid_busy", 32'(busy), 0);
        wb_ready = 1'b1;
        saw_wb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (wb_valid) saw_wb = 1'b1;
            tick();
        end
        wb_ready = 1'b0;
        check("rst_mid_no_wb", 32'(saw_wb), 0);

        // flags 1001 via 0xFFFF+1, then condition sweep
        issue(3'b000, 16'hFFFF, 16'h0001, 3'd2, 1'b1, 1'b1, 16'h0000);
        wait_wb();
        handshake();
        check("zc_flags", 32'(flags), 32'h9);
        cond_exp = 8'b0011_0011;
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1 check($sformatf("cond_%0d", s), 32'(cond_true), 32'(cond_exp[s]));
        end

        tick(); tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Initiator side of the 16-bit ALU interface.
- Accepts decoded ALU commands over a valid/ready handshake and drives the ALU's data1, data2 and 3-bit control inputs from registers.
- Waits a fixed settle time: one cycle for simple ops, extra cycles for multiply.
- Captures the ALU result and status, returns the result on a valid/ready writeback port, and holds the architectural flag register (Z,N,V,C) that branch logic queries.

Parameters:
- WIDTH, 16, datapath width; must match ALU.
- MUL_WAIT, 2, extra settle cycles for op 3'b100 (multiply); legal range 0..7.
- DST_W, 3, destination register index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept.
- cmd_op  in  3  ALU control code (000 add … 111 pass data2).
- cmd_a  in  WIDTH  operand 1.
- cmd_b  in  WIDTH  operand 2.
- cmd_dst  in  DST_W  writeback destination tag.
- cmd_setflags  in  1  commit flags on writeback.
- alu_data1  out  WIDTH  registered ALU operand 1.
- alu_data2  out  WIDTH  registered ALU operand 2.
- alu_ctrl  out  3  registered ALU control.
- alu_result  in  WIDTH  ALU result.
- alu_status  in  16  ALU status; bits 15:12 = Z,N,V,C.
- wb_valid  out  1  result available.
- wb_ready  in  1  consumer takes result.
- wb_data  out  WIDTH  captured result.
- wb_dst  out  DST_W  captured destination tag.
- flags  out  4  committed {Z,N,V,C}.
- cond_sel  in  3  condition select.
- cond_true  out  1  condition evaluated on committed flags.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Single clock, synchronous active-high rst. On reset every output and register returns to 0, except cmd_ready, which is 1:
  - state=IDLE, wb_valid=0, wb_data=0, wb_dst=0, flags=0, alu_data1/2=0, alu_ctrl=0, busy=0.
  - Any in-flight op is discarded; no writeback and no flag commit occur.
- Handshake: cmd_ready = (state==IDLE). When cmd_valid&&cmd_ready:
  - latch cmd_a→alu_data1, cmd_b→alu_data2, cmd_op→alu_ctrl, plus cmd_dst and cmd_setflags;
  - cnt = (cmd_op==3'b100) ? MUL_WAIT : 0; go to EXEC.
- EXEC: if cnt!=0, decrement cnt. If cnt==0:
  - capture alu_result→wb_data;
  - pending flags: Z = (alu_result==0), N = alu_result[15], V = alu_status[13], C = alu_status[12];
  - go to WB.
  - Z and N are always recomputed locally; ALU status bits 15:14 are ignored.
- WB: wb_valid=1. wb_data and wb_dst hold stable until wb_ready.
  - On wb_valid&&wb_ready: if setflags, flags<=pending; go to IDLE. New flags are visible the next cycle.
- Latency from accept cycle T: non-mul wb_valid at T+2; mul at T+2+MUL_WAIT. Next accept no earlier than the cycle after the WB handshake.
- ALU operand/control registers hold their last values while IDLE; no glitching between ops.
- cond_true is combinational from committed flags:
  - 000 always; 001 EQ (Z); 010 NE (!Z); 011 LT (N^V);
  - 100 GE (!(N^V)); 101 CS (C); 110 VS (V); 111 never.
- During WB, cond_true still reflects the old flags. Consumers needing new flags wait one cycle after the handshake.
- cmd_valid while busy is ignored and not queued. The upstream source must hold the command until cmd_ready.
- Unknown or reserved ops do not exist: all 8 codes pass through unchanged.

Decomposition:
- Shared package alu_pkg:
  - op codes: OP_ADD 000, OP_ADD1 001, OP_SUB 010, OP_ADD3 011, OP_MUL 100, OP_AND 101, OP_SLL 110, OP_MOV 111;
  - flag bit indices (Z=3, N=2, V=1, C=0), status field position 15:12;
  - cond_sel codes;
  - state enum IDLE/EXEC/WB.
- One natural sub-module: alu_cond_eval (flags + cond_sel → cond_true), reusable by branch unit.

Test Plan:
- Reset, then add 0x7FFF+0x0001, ALU reports V=1, setflags=1 → wb_valid at T+2, wb_data=0x8000; after handshake flags=0110 (Z0 N1 V1 C0); cond LT (011) = 0.
- Mul 0x0003×0xFFFE, MUL_WAIT=2 → wb_valid exactly at T+4, wb_data=0xFFFA; cmd_ready low for cycles T+1..handshake.
- Sub 0x0005−0x0005 with setflags=0 → wb_data=0x0000; flags unchanged from prior value; busy drops after handshake.
- Backpressure: hold wb_ready=0 for 5 cycles on pass (111) b=0x1234 → wb_data=0x1234 and wb_dst stable, cmd_ready=0 throughout; second cmd_valid ignored.
- Assert rst during EXEC of a mul → next cycle state IDLE, wb_valid=0, flags=0, cmd_ready=1; no writeback ever appears for that op.
- cond_sel sweep with flags forced to 1001 (Z=1, C=1) → EQ=1, NE=0, CS=1, VS=0, LT=0, GE=1, always=1, never=0.
